// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the 4-lane round-robin mux arbiter: FSM encodings,
// lane select codes and a one-hot helper.
package mux4_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_D = 2'd3;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: returns the first requesting lane
// in the order ptr, ptr+1, ... mod 4, plus a flag that any lane requests.
module rr_pick4
    import mux4_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] pick,
    output logic       any
);

    always_comb begin
        pick = ptr;
        any  = 1'b0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if (!any && req[ptr + 2'(i)]) begin
                pick = ptr + 2'(i);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a shared 4:1 mux; grant is held until the owner
// drops its request. Optional forced release after MAX_HOLD cycles: MUX4_ARB_TIMEOUT_EN.
module mux4_rr_arbiter
    import mux4_pkg::*;
#(
    parameter int W        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] din,
    output logic [3:0]     gnt,
    output logic [1:0]     sel,
    output logic           busy,
    output logic [W-1:0]   dout,
    output logic           timeout
);

    if (MAX_HOLD < 1) begin : g_bad_cfg
        $error("MAX_HOLD must be at least 1");
    end

    logic [1:0] state;
    logic [1:0] ptr;
    logic [1:0] pick;
    logic       any;
    logic       expire;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (ptr),
        .pick (pick),
        .any  (any)
    );

`ifdef MUX4_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold;
    logic          timeout_q;

    // hold counts GRANT cycles already served, so the last allowed cycle sees MAX_HOLD-1
    assign expire = (state == ST_GRANT) && (hold == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= expire && req[sel];
            if (state == ST_GRANT) hold <= hold + 1'b1;
            else                   hold <= '0;
        end
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= '0;
            sel   <= SEL_A;
            ptr   <= SEL_A;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        state <= ST_GRANT;
                        gnt   <= onehot4(pick);
                        sel   <= pick;
                    end
                end
                ST_GRANT: begin
                    if (!req[sel] || expire) begin
                        state <= ST_RELEASE;
                        gnt   <= '0;
                        ptr   <= sel + 2'd1;
                    end
                end
                ST_RELEASE: state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    assign busy = (state == ST_GRANT);
    assign dout = busy ? din[int'(sel)*W +: W] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed plus randomized bench for mux4_rr_arbiter against an owner/gap
// reference model; define MUX4_ARB_TIMEOUT_EN to exercise forced release.
module tb_mux4_rr_arbiter;

    localparam int W    = 8;
    localparam int HOLD = 4;
`ifdef MUX4_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req = '0;
    logic [4*W-1:0] din = '0;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic           busy;
    logic [W-1:0]   dout;
    logic           timeout;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 if none), cycles left before arbitration,
    // priority pointer, cycles held, last select and forced-release flag.
    int         m_owner = -1;
    int         m_gap   = 0;
    int         m_ptr   = 0;
    int         m_held  = 0;
    logic [1:0] m_sel   = 2'd0;
    bit         m_to    = 1'b0;

    mux4_rr_arbiter #(.W(W), .MAX_HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .dout    (dout),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [3:0] r, input bit rs);
        m_to = 1'b0;
        if (rs) begin
            m_owner = -1; m_gap = 0; m_ptr = 0; m_sel = 2'd0; m_held = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner] || (TO_EN && m_held >= HOLD)) begin
                m_to    = r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int lane;
                lane = (m_ptr + k) % 4;
                if (r[lane]) begin
                    m_owner = lane;
                    m_sel   = 2'(lane);
                    m_held  = 1;
                    break;
                end
            end
        end
    endtask

    task automatic step(input logic [3:0] r, input bit rs = 1'b0);
        logic [31:0] exp_gnt;
        logic [31:0] exp_dout;
        req = r;
        rst = rs;
        din = $urandom;
        @(posedge clk);
        model_edge(r, rs);
        #1;
        exp_gnt  = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        exp_dout = (m_owner >= 0) ? 32'(din[int'(m_sel)*W +: W]) : 32'd0;
        chk("gnt",     32'(gnt),     exp_gnt);
        chk("sel",     32'(sel),     32'(m_sel));
        chk("busy",    32'(busy),    32'(m_owner >= 0));
        chk("dout",    32'(dout),    exp_dout);
        chk("timeout", 32'(timeout), 32'(m_to));
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;

        // 1: reset state, single requester, release
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_sel", 32'(sel), 32'd0);
        step(4'b0001);
        chk("first_grant", 32'(gnt), 32'b0001);
        step(4'b0001);
        step(4'b0000);
        chk("release_gnt", 32'(gnt), 32'd0);
        step(4'b0000);

        // 2: all lanes requesting, owner drops for one cycle each tenure
        step(4'b0000, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(4'b1111);
            chk("rr_order", 32'(gnt), 32'd1 << order[k]);
            step(4'b1111 ^ (4'b0001 << order[k]));
            step(4'b1111);
        end

        // 3: pointer wrap after D, and ptr=3 favours D over A
        step(4'b0000, 1'b1);
        step(4'b1000);
        step(4'b0000);
        step(4'b0000);
        step(4'b0001);
        chk("wrap_to_a", 32'(gnt), 32'b0001);
        step(4'b0000);
        step(4'b0000);
        step(4'b0100);
        step(4'b0000);
        step(4'b1001);
        step(4'b1001);
        chk("d_before_a", 32'(gnt), 32'b1000);

        // 4: other requests change on the same edge the owner B drops
        step(4'b0000, 1'b1);
        step(4'b0010);
        step(4'b1110);
        step(4'b1100);
        chk("simul_release", 32'(gnt), 32'd0);
        step(4'b1100);
        step(4'b1100);
        chk("simul_grant_c", 32'(gnt), 32'b0100);

        // 5: reset in the middle of GRANT(C)
        step(4'b1100, 1'b1);
        chk("midrst_gnt",  32'(gnt),  32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sel",  32'(sel),  32'd0);
        step(4'b0100);
        chk("post_rst_c", 32'(gnt), 32'b0100);

        // 6: continuous A+B request, with and without forced release
        step(4'b0000, 1'b1);
`ifdef MUX4_ARB_TIMEOUT_EN
        for (int k = 0; k < 4; k++) begin
            step(4'b0011);
            chk("hold_a", 32'(gnt), 32'b0001);
        end
        step(4'b0011);
        chk("timeout_pulse", 32'(timeout), 32'd1);
        step(4'b0011);
        chk("timeout_gap", 32'(timeout), 32'd0);
        step(4'b0011);
        chk("after_to_b", 32'(gnt), 32'b0010);
        for (int k = 0; k < 20; k++) step(4'b0011);
`else
        for (int k = 0; k < 110; k++) step(4'b0011);
        chk("long_hold_a", 32'(gnt), 32'b0001);
        chk("no_timeout", 32'(timeout), 32'd0);
`endif

        // 7: randomized traffic with occasional reset
        r = 4'b0000;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            step(r, $urandom_range(0, 59) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
